// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Next-PC sequencer and issue controller for the fetch stage. Each cycle it
// picks the value loaded into the fetch PC register (sequential PC+4, branch
// target, or hold), qualifies the fetched instruction for decode, and manages
// hazard stalls, taken-branch redirects with a flush window, and HALT.
//
// Ports:
//   clk_i        - clock, all state changes on the rising edge
//   rst_i        - synchronous active-high reset
//   seq_pc_i     - fetch stage's PC+4
//   instr_i      - instruction at the current fetch PC
//   stall_i      - hazard-unit stall request
//   br_taken_i   - branch resolved taken in execute
//   br_target_i  - branch target, valid with br_taken_i
//   next_pc_o    - value for the fetch PC register (combinational)
//   pc_o         - shadow of the current fetch PC
//   valid_o      - instr_i issues to decode this cycle (combinational)
//   flush_o      - squash younger pipeline registers (combinational)
//   halted_o     - fetch is halted (registered)
//   issue_cnt_o  - wrapping count of issued instructions (registered)

module fetch_ctrl #(
  parameter int             PWIDTH       = 16,
  parameter int             IWIDTH       = 24,
  parameter int             OPW          = 4,
  parameter logic [OPW-1:0] HALT_OP      = 4'hF,
  parameter int             FLUSH_CYCLES = 1,
  parameter int             CWIDTH       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [PWIDTH-1:0] seq_pc_i,
  input  logic [IWIDTH-1:0] instr_i,
  input  logic              stall_i,
  input  logic              br_taken_i,
  input  logic [PWIDTH-1:0] br_target_i,
  output logic [PWIDTH-1:0] next_pc_o,
  output logic [PWIDTH-1:0] pc_o,
  output logic              valid_o,
  output logic              flush_o,
  output logic              halted_o,
  output logic [CWIDTH-1:0] issue_cnt_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_e            state_q, state_d;
  logic [3:0]        fcnt_q, fcnt_d;
  logic [PWIDTH-1:0] pc_q;
  logic [CWIDTH-1:0] cnt_q;
  logic              is_halt_op;

  assign is_halt_op = (instr_i[IWIDTH-1 -: OPW] == HALT_OP);

  // State, flush counter, PC shadow and issue counter. The shadow simply
  // follows next_pc_o, which is forced to 0 during reset so it tracks the
  // fetch PC register exactly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      fcnt_q  <= 4'd0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pc_q    <= next_pc_o;
      if (valid_o) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Next-state logic. A redirect overrides every state, including HALT,
  // because the HALT may have been fetched down the wrong path.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (br_taken_i) begin
      if (FLUSH_INIT != 4'd0) begin
        state_d = FLUSH;
        fcnt_d  = FLUSH_INIT;
      end else begin
        state_d = RUN;
        fcnt_d  = 4'd0;
      end
    end else begin
      case (state_q)
        FLUSH: begin
          fcnt_d = fcnt_q - 4'd1;
          // Leaving on the last counted cycle keeps flush_o high for exactly
          // FLUSH_CYCLES cycles after the redirect cycle.
          if (fcnt_q <= 4'd1) begin
            state_d = RUN;
            fcnt_d  = 4'd0;
          end
        end
        HALT: begin
          state_d = HALT;
        end
        RUN: begin
          if (!stall_i && is_halt_op) begin
            state_d = HALT;
          end
        end
        default: begin
          state_d = RUN;
          fcnt_d  = 4'd0;
        end
      endcase
    end
  end

  // Output logic. Holding means reloading pc_q; the HALT instruction itself
  // still issues, but the PC does not advance past it.
  always_comb begin
    next_pc_o = pc_q;
    valid_o   = 1'b0;
    flush_o   = 1'b0;
    if (rst_i) begin
      next_pc_o = '0;
    end else if (br_taken_i) begin
      next_pc_o = br_target_i;
      flush_o   = 1'b1;
    end else begin
      case (state_q)
        FLUSH: begin
          flush_o = 1'b1;
        end
        HALT: begin
          next_pc_o = pc_q;
        end
        RUN: begin
          if (stall_i) begin
            next_pc_o = pc_q;
          end else if (is_halt_op) begin
            valid_o = 1'b1;
          end else begin
            next_pc_o = seq_pc_i;
            valid_o   = 1'b1;
          end
        end
        default: begin
          next_pc_o = pc_q;
        end
      endcase
    end
  end

  assign pc_o        = pc_q;
  assign halted_o    = (state_q == HALT);
  assign issue_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
// Directed and random stimulus for fetch_ctrl, checked every cycle against a
// behavioural model that tracks the fetch PC, the number of flush cycles still
// owed, a halted flag and the issue count.

module tb_fetch_ctrl;

  localparam int PW = 16;
  localparam int IW = 24;
  localparam int FC = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [PW-1:0] seq_pc_i;
  logic [IW-1:0] instr_i;
  logic          stall_i;
  logic          br_taken_i;
  logic [PW-1:0] br_target_i;
  logic [PW-1:0] next_pc_o;
  logic [PW-1:0] pc_o;
  logic          valid_o;
  logic          flush_o;
  logic          halted_o;
  logic [CW-1:0] issue_cnt_o;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .PWIDTH      (PW),
    .IWIDTH      (IW),
    .OPW         (4),
    .HALT_OP     (4'hF),
    .FLUSH_CYCLES(FC),
    .CWIDTH      (CW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .seq_pc_i   (seq_pc_i),
    .instr_i    (instr_i),
    .stall_i    (stall_i),
    .br_taken_i (br_taken_i),
    .br_target_i(br_target_i),
    .next_pc_o  (next_pc_o),
    .pc_o       (pc_o),
    .valid_o    (valid_o),
    .flush_o    (flush_o),
    .halted_o   (halted_o),
    .issue_cnt_o(issue_cnt_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model
  logic [PW-1:0] m_pc     = '0;
  int            m_owed   = 0;
  bit            m_halted = 1'b0;
  int            m_cnt    = 0;
  logic [PW-1:0] e_next;
  bit            e_valid;
  bit            e_flush;

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Derive the expected combinational outputs from the rules, then compare
  // every output of the DUT.
  task automatic checkOutput();
    e_next  = m_pc;
    e_valid = 1'b0;
    e_flush = 1'b0;
    if (rst_i) begin
      e_next = '0;
    end else if (br_taken_i) begin
      e_next  = br_target_i;
      e_flush = 1'b1;
    end else if (m_owed > 0) begin
      e_flush = 1'b1;
    end else if (m_halted) begin
      e_next = m_pc;
    end else if (stall_i) begin
      e_next = m_pc;
    end else if (instr_i[IW-1 -: 4] == 4'hF) begin
      e_valid = 1'b1;
    end else begin
      e_next  = seq_pc_i;
      e_valid = 1'b1;
    end
    checkOne("next_pc", 32'(next_pc_o), 32'(e_next));
    checkOne("pc", 32'(pc_o), 32'(m_pc));
    checkOne("valid", 32'(valid_o), 32'(e_valid));
    checkOne("flush", 32'(flush_o), 32'(e_flush));
    checkOne("halted", 32'(halted_o), 32'(m_halted));
    checkOne("issue_cnt", 32'(issue_cnt_o), 32'(m_cnt));
  endtask

  // One clock cycle: drive inputs after the falling edge, check before the
  // rising edge, advance the model on the rising edge.
  task automatic applyStimulus(input bit rst, input bit stall, input bit br,
                               input logic [PW-1:0] tgt, input logic [IW-1:0] instr);
    @(negedge clk);
    rst_i       = rst;
    stall_i     = stall;
    br_taken_i  = br;
    br_target_i = tgt;
    instr_i     = instr;
    seq_pc_i    = m_pc + 16'd4;
    #1;
    checkOutput();
    @(posedge clk);
    if (rst) begin
      m_pc     = '0;
      m_owed   = 0;
      m_halted = 1'b0;
      m_cnt    = 0;
    end else begin
      if (e_valid) m_cnt = (m_cnt + 1) % (1 << CW);
      if (br) begin
        m_owed   = FC;
        m_halted = 1'b0;
      end else if (m_owed > 0) begin
        m_owed--;
      end else if (!m_halted && !stall && instr[IW-1 -: 4] == 4'hF) begin
        m_halted = 1'b1;
      end
      m_pc = e_next;
    end
    #1;
  endtask

  function automatic logic [IW-1:0] mkInstr(input bit halt);
    logic [3:0] op;
    op = halt ? 4'hF : 4'($urandom_range(0, 14));
    return {op, 20'($urandom)};
  endfunction

  task automatic seqStep();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, mkInstr(1'b0));
  endtask

  initial begin
    rst_i       = 1'b1;
    stall_i     = 1'b0;
    br_taken_i  = 1'b0;
    br_target_i = '0;
    instr_i     = '0;
    seq_pc_i    = '0;

    // Reset
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, mkInstr(1'b0));
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, mkInstr(1'b0));
    checkOne("rst_pc", 32'(pc_o), 32'h0);
    checkOne("rst_cnt", 32'(issue_cnt_o), 32'h0);

    // Sequential run 0 -> 4 -> 8, stall two cycles at 8, then 12
    seqStep();
    seqStep();
    checkOne("seq_pc8", 32'(pc_o), 32'h8);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, mkInstr(1'b0));
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, mkInstr(1'b1));
    checkOne("stall_pc", 32'(pc_o), 32'h8);
    checkOne("stall_cnt", 32'(issue_cnt_o), 32'h2);
    seqStep();
    checkOne("seq_pc12", 32'(pc_o), 32'hC);
    checkOne("seq_cnt3", 32'(issue_cnt_o), 32'h3);

    // Advance to 0x20, redirect to 0x100 with a two-cycle flush window
    repeat (5) seqStep();
    checkOne("pre_br_pc", 32'(pc_o), 32'h20);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0100, mkInstr(1'b0));
    checkOne("br_pc", 32'(pc_o), 32'h100);
    seqStep();
    seqStep();
    seqStep();

    // Redirect during a stall, then a redirect that restarts the flush window
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0200, mkInstr(1'b0));
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, mkInstr(1'b0));
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0010, mkInstr(1'b0));
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, mkInstr(1'b1));
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, mkInstr(1'b1));

    // HALT at 0x10 issues once and parks fetch until a redirect
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 24'hF00000);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0, 16'h0, mkInstr(1'($urandom_range(0, 1))));
    end
    checkOne("halt_pc", 32'(pc_o), 32'h10);
    checkOne("halt_flag", 32'(halted_o), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0040, mkInstr(1'b0));
    checkOne("unhalt", 32'(halted_o), 32'h0);
    checkOne("unhalt_pc", 32'(pc_o), 32'h40);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 99) < 2),
                    1'($urandom_range(0, 99) < 25),
                    1'($urandom_range(0, 99) < 10),
                    16'($urandom) & 16'hFFFC,
                    mkInstr(1'($urandom_range(0, 99) < 6)));
    end

    // Counter wrap after 17 issues, then reset in the middle of a flush
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, mkInstr(1'b0));
    repeat (17) seqStep();
    checkOne("wrap_cnt", 32'(issue_cnt_o), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0300, mkInstr(1'b0));
    seqStep();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, mkInstr(1'b0));
    checkOne("midrst_pc", 32'(pc_o), 32'h0);
    checkOne("midrst_cnt", 32'(issue_cnt_o), 32'h0);
    seqStep();
    seqStep();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
